data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the MEM stage of the 64-bit pipelined CPU. Accepts the
//  registered load/store request (address, store data, SW/LW strobes) presented by the
//  EX->MEM pipeline register, performs a word access with WAIT_CYCLES of latency, and
//  stalls the pipeline until the access completes. Load data feeds the MEM->WB register.
// PARAMETERS
//  DATA_W      64  data word width (bits)
//  DEPTH       32  number of DATA_W words in the array
//  WAIT_CYCLES 2   extra BUSY cycles before an access completes (0 allowed)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  daddrbus     in   64      byte address from EX->MEM register
//  databus_in   in   64      store data from EX->MEM register
//  SW_MEM       in   1       store request
//  LW_MEM       in   1       load request
//  databus_out  out  64      load data, registered, held until next completed load
//  stall        out  1       freeze upstream pipeline registers / PC
//  mem_done     out  1       one-cycle pulse: access (or rejected request) finished
//  addr_err     out  1       one-cycle pulse with mem_done: request rejected
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset: state=IDLE, counter=0,
//    databus_out=0, mem_done=0, addr_err=0. Array contents not touched by reset.
//  - FSM states IDLE, BUSY, RESP.
//    IDLE: if SW_MEM|LW_MEM: latch addr, data, op; counter<=WAIT_CYCLES;
//          next = BUSY if WAIT_CYCLES>0 else RESP. Otherwise stay.
//    BUSY: counter decrements; when counter==1 next = RESP.
//    RESP: mem_done=1 (addr_err per below); next = IDLE unconditionally.
//  - Access happens on the edge entering RESP: store writes array, load captures
//    array word into databus_out. Stores leave databus_out unchanged.
//  - stall (combinational) = (IDLE & (SW_MEM|LW_MEM)) | BUSY. Low in RESP so the
//    pipeline advances on that edge; request inputs in RESP are ignored, next request
//    is sampled in the following IDLE cycle.
//  - Latency: request visible in cycle 0 -> mem_done in cycle WAIT_CYCLES+1;
//    stall high for WAIT_CYCLES+1 cycles. Back-to-back requests: one IDLE cycle gap.
//  - Word index = daddrbus[3+$clog2(DEPTH)-1:3]. Rejected (no write, databus_out
//    forced 0 for loads, addr_err=1 in RESP) if: daddrbus[2:0]!=0, or any address bit
//    above the index range is set, or SW_MEM&LW_MEM both high. Rejected requests still
//    take full WAIT_CYCLES latency.
//  - Latched request used throughout; input changes during BUSY have no effect.
//  - Reset mid-operation: reset wins on every edge; an in-flight store is dropped,
//    no mem_done pulse is produced, FSM returns to IDLE.
//  - mem_done and addr_err are registered-state decodes; never high outside RESP.
// STRUCTURE
//  - Shared package dmem_pkg: state enum {IDLE,BUSY,RESP}, DATA_W default, word-offset
//    constant (3), ADDR_W=64.
//  - One sub-module: sram_1rw (single-port, synchronous write, synchronous read,
//    DEPTH x DATA_W). FSM, counter, address check and output register in top level.
// TESTING
//  1. Reset then SW addr 0x10 data 0xDEADBEEF_CAFEF00D, WAIT_CYCLES=2 -> stall high
//     cycles 0-2, mem_done cycle 3, addr_err=0; then LW 0x10 -> databus_out
//     =0xDEADBEEF_CAFEF00D at mem_done.
//  2. LW 0x13 (misaligned) and LW 0x100 (DEPTH=32, out of range) -> addr_err=1 with
//     mem_done, databus_out=0, array unchanged (reread 0x10 still correct).
//  3. SW and LW both high addr 0x8 -> addr_err=1, no write to word 1.
//  4. Reset asserted in BUSY of SW 0x18 data 0x55 -> IDLE next cycle, stall=0, no
//     mem_done; later LW 0x18 returns prior content, not 0x55.
//  5. WAIT_CYCLES=0 build: LW held continuously -> stall 1,0 pattern, mem_done every
//     2nd cycle, one access per request.
//  6. Inputs toggled during BUSY (addr 0x20->0x28) -> access uses latched 0x20.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W_DFLT = 64;  // default data word width
  localparam int WORD_OFF    = 3;   // byte-offset bits within a 64-bit word
  localparam int ADDR_W      = 64;  // byte address width

  // A request is bad if it is not word aligned or addresses past the array.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr, input int idx_w);
    logic [ADDR_W-1:0] hi;
    hi = addr >> (WORD_OFF + idx_w);
    return (addr[WORD_OFF-1:0] != '0) || (hi != '0);
  endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port DEPTH x DATA_W array, synchronous write and synchronous read.
// Latency: read data appears in rdata_o the cycle after en&~we; writes land on the edge.
// Backpressure: none; one access per enabled cycle, rdata_o holds between reads.
module sram_1rw
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdat_i,
  output logic [DATA_W-1:0] rdat_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdat_q;

  // Array access: contents and read register are intentionally never reset
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdat_i;
      end else begin
        rdat_q <= mem_q[addr_i];
      end
    end
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: latches a request, waits WAIT_CYCLES, then accesses the array.
// Latency: request in cycle 0 -> mem_done pulse in cycle WAIT_CYCLES+1.
// Backpressure: stall held for WAIT_CYCLES+1 cycles, low in RESP so the pipeline advances.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DFLT,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] daddrbus,
  input  logic [DATA_W-1:0] databus_in,
  input  logic              SW_MEM,
  input  logic              LW_MEM,
  output logic [DATA_W-1:0] databus_out,
  output logic              stall,
  output logic              mem_done,
  output logic              addr_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdat_q;
  logic              store_q, load_q, err_q;
  // When set, databus_out reads as zero (after reset or a rejected load)
  logic              zero_q;

  logic              req, req_err;
  logic [IDX_W-1:0]  req_idx;
  logic              enter_resp;
  logic              acc_store, acc_load, acc_err;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] acc_wdat;
  logic [DATA_W-1:0] sram_rdat;

  assign req     = SW_MEM | LW_MEM;
  assign req_idx = daddrbus[WORD_OFF +: IDX_W];
  assign req_err = addr_bad(daddrbus, IDX_W) | (SW_MEM & LW_MEM);

  // The array is touched on the edge that enters RESP; a reset on that edge drops the access.
  assign enter_resp = (state_d == RESP) & ~reset;

  // With zero wait cycles the access edge is the request edge, so take the live inputs in IDLE
  always_comb begin
    if (state_q == IDLE) begin
      acc_store = SW_MEM;
      acc_load  = LW_MEM;
      acc_err   = req_err;
      acc_idx   = req_idx;
      acc_wdat  = databus_in;
    end else begin
      acc_store = store_q;
      acc_load  = load_q;
      acc_err   = err_q;
      acc_idx   = idx_q;
      acc_wdat  = wdat_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (WAIT_CYCLES > 0) ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: stall, done and error decodes
  always_comb begin
    stall       = ((state_q == IDLE) & req) | (state_q == BUSY);
    mem_done    = (state_q == RESP);
    addr_err    = (state_q == RESP) & err_q;
    databus_out = zero_q ? '0 : sram_rdat;
  end

  // Request latch, wait counter and load-result qualifier
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      store_q <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      if ((state_q == IDLE) && req) begin
        cnt_q   <= CNT_W'(WAIT_CYCLES);
        idx_q   <= req_idx;
        wdat_q  <= databus_in;
        store_q <= SW_MEM;
        load_q  <= LW_MEM;
        err_q   <= req_err;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (enter_resp && acc_load) begin
        zero_q <= acc_err;
      end
    end
  end

  sram_1rw #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_sram (
    .clk    (clk),
    .en_i   (enter_resp & ~acc_err),
    .we_i   (acc_store),
    .addr_i (acc_idx),
    .wdat_i (acc_wdat),
    .rdat_o (sram_rdat)
  );

endmodule
